// File: rtl/branch_target_reader.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Registered one-cycle lookup, plus a resolve/update path that raises a registered redirect.
module branch_target_reader #(
  parameter int Width   = 32,
  parameter int Entries = 128,
  parameter int TagW    = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] pc_if_i,
  input  logic             fetch_valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             predict_taken_o,
  output logic [Width-1:0] predicted_pc_o,
  output logic             pred_valid_o,
  input  logic             upd_valid_i,
  input  logic [Width-1:0] upd_pc_i,
  input  logic [Width-1:0] upd_target_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_taken_i,
  input  logic [Width-1:0] upd_pred_pc_i,
  output logic             mispredict_o,
  output logic [Width-1:0] correct_pc_o
);

  localparam int IdxW = $clog2(Entries);
  localparam int TagLo = IdxW + 2;

  logic [Entries-1:0] valid_q;
  logic [1:0]         ctr_q    [Entries];
  logic [TagW-1:0]    tag_q    [Entries];
  logic [Width-1:0]   target_q [Entries];

  logic [IdxW-1:0]  l_idx, u_idx;
  logic [TagW-1:0]  l_tag, u_tag;
  logic             l_hit, l_taken, u_hit, accept;
  logic [Width-1:0] l_next;
  logic [1:0]       ctr_next;

  assign l_idx = pc_if_i[TagLo-1:2];
  assign l_tag = pc_if_i[TagLo+TagW-1:TagLo];
  assign u_idx = upd_pc_i[TagLo-1:2];
  assign u_tag = upd_pc_i[TagLo+TagW-1:TagLo];

  // The table is read at the accepting edge and the result registered, so a
  // same-edge update is never visible to that lookup (read-before-write).
  assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign l_taken = l_hit && ctr_q[l_idx][1];
  assign l_next  = l_taken ? target_q[l_idx] : pc_if_i + Width'(4);
  assign accept  = fetch_valid_i && !stall_i && !flush_i;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    ctr_next = ctr_q[u_idx];
    if (upd_taken_i) begin
      if (ctr_next != 2'b11) ctr_next = ctr_next + 2'b01;
    end else if (ctr_next != 2'b00) begin
      ctr_next = ctr_next - 2'b01;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_o    <= 1'b0;
      predict_taken_o <= 1'b0;
      predicted_pc_o  <= '0;
    end else begin
      if (flush_i)       pred_valid_o <= 1'b0;
      else if (!stall_i) pred_valid_o <= fetch_valid_i;
      if (accept) begin
        predict_taken_o <= l_taken;
        predicted_pc_o  <= l_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < Entries; i++) ctr_q[i] <= 2'b01;
    end else if (upd_valid_i) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next;
      end else if (upd_taken_i) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

  // Tag rewrite on a taken hit is harmless: it already matches.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i && upd_taken_i) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mispredict_o <= 1'b0;
      correct_pc_o <= '0;
    end else begin
      mispredict_o <= upd_valid_i &&
                      ((upd_pred_taken_i != upd_taken_i) ||
                       (upd_taken_i && (upd_pred_pc_i != upd_target_i)));
      if (upd_valid_i)
        correct_pc_o <= upd_taken_i ? upd_target_i : upd_pc_i + Width'(4);
    end
  end

endmodule

// File: tb/tb_branch_target_reader.sv
// Bench for branch_target_reader: directed scenarios with literal expectations,
// plus a table-level reference model compared against the outputs every cycle.
module tb_branch_target_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_if = '0;
  logic        fetch_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        predict_taken, pred_valid, mispredict;
  logic [31:0] predicted_pc, correct_pc;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_pc = '0;

  int checks = 0;
  int passes = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  branch_target_reader #(.Width(32), .Entries(128), .TagW(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .pc_if_i(pc_if), .fetch_valid_i(fetch_valid), .stall_i(stall), .flush_i(flush),
    .predict_taken_o(predict_taken), .predicted_pc_o(predicted_pc), .pred_valid_o(pred_valid),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_target_i(upd_target),
    .upd_taken_i(upd_taken), .upd_pred_taken_i(upd_pred_taken), .upd_pred_pc_i(upd_pred_pc),
    .mispredict_o(mispredict), .correct_pc_o(correct_pc)
  );

  // Reference model: table of entries keyed by pc/4 mod 128, tag pc/512 mod 32.
  bit          m_valid [128];
  int          m_tag   [128];
  logic [31:0] m_tgt   [128];
  int          m_ctr   [128];
  logic        e_pv, e_pt, e_mp;
  logic [31:0] e_ppc, e_cpc;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % 128);
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc / 512) % 32);
  endfunction

  function automatic bit hit_of(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit taken_of(logic [31:0] pc);
    return hit_of(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 1;
      end
      e_pv <= 1'b0; e_pt <= 1'b0; e_ppc <= '0; e_mp <= 1'b0; e_cpc <= '0;
    end else begin
      if (flush)       e_pv <= 1'b0;
      else if (!stall) e_pv <= fetch_valid;
      if (fetch_valid && !stall && !flush) begin
        e_pt  <= taken_of(pc_if);
        e_ppc <= taken_of(pc_if) ? m_tgt[idx_of(pc_if)] : pc_if + 32'd4;
      end
      e_mp <= upd_valid && ((upd_pred_taken != upd_taken) ||
                            (upd_taken && upd_pred_pc != upd_target));
      if (upd_valid) e_cpc <= upd_taken ? upd_target : upd_pc + 32'd4;
      if (upd_valid && hit_of(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[idx_of(upd_pc)] <= (m_ctr[idx_of(upd_pc)] == 3) ? 3 : m_ctr[idx_of(upd_pc)] + 1;
          m_tgt[idx_of(upd_pc)] <= upd_target;
        end else begin
          m_ctr[idx_of(upd_pc)] <= (m_ctr[idx_of(upd_pc)] == 0) ? 0 : m_ctr[idx_of(upd_pc)] - 1;
        end
      end else if (upd_valid && upd_taken) begin
        m_valid[idx_of(upd_pc)] <= 1'b1;
        m_tag[idx_of(upd_pc)]   <= tag_of(upd_pc);
        m_tgt[idx_of(upd_pc)]   <= upd_target;
        m_ctr[idx_of(upd_pc)]   <= 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model pred_valid", 32'(pred_valid), 32'(e_pv));
      if (e_pv) begin
        chk("model predict_taken", 32'(predict_taken), 32'(e_pt));
        chk("model predicted_pc", predicted_pc, e_ppc);
      end
      chk("model mispredict", 32'(mispredict), 32'(e_mp));
      if (e_mp) chk("model correct_pc", correct_pc, e_cpc);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0; upd_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    pc_if = pc; fetch_valid = 1'b1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                     input logic ptk, input logic [31:0] ppc);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    upd_pred_taken = ptk; upd_pred_pc = ppc;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    armed = 1'b1;
    chk("reset pred_valid", 32'(pred_valid), 32'd0);
    chk("reset predict_taken", 32'(predict_taken), 32'd0);
    chk("reset predicted_pc", predicted_pc, 32'd0);
    chk("reset mispredict", 32'(mispredict), 32'd0);
    chk("reset correct_pc", correct_pc, 32'd0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc,
                        input logic tk, input logic [31:0] npc);
    fetch(pc); cyc(); idle();
    chk({name, " valid"}, 32'(pred_valid), 32'd1);
    chk({name, " taken"}, 32'(predict_taken), 32'(tk));
    chk({name, " pc"}, predicted_pc, npc);
  endtask

  function automatic logic [31:0] pick_pc(int unsigned r);
    case (r % 5)
      0: return 32'h0000_1000;
      1: return 32'h0000_3000;
      2: return 32'h0000_1040;
      3: return 32'hFFFF_FFFC;
      default: return 32'h0000_2204;
    endcase
  endfunction

  initial begin
    #2;
    do_reset();
    cyc();

    lookup("cold", 32'h0000_1000, 1'b0, 32'h0000_1004);
    cyc();
    chk("cold one-shot", 32'(pred_valid), 32'd0);

    upd(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_1004);
    cyc(); idle();
    chk("alloc mispredict", 32'(mispredict), 32'd1);
    chk("alloc correct_pc", correct_pc, 32'h0000_2000);
    cyc();
    chk("alloc pulse ends", 32'(mispredict), 32'd0);
    lookup("alloc hit", 32'h0000_1000, 1'b1, 32'h0000_2000);

    for (int i = 0; i < 3; i++) begin
      upd(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b1, 32'h0000_2000);
      cyc();
      chk("taken update no redirect", 32'(mispredict), 32'd0);
    end
    idle();
    upd(32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000);
    cyc(); idle();
    chk("not-taken redirect", 32'(mispredict), 32'd1);
    chk("not-taken correct_pc", correct_pc, 32'h0000_1004);
    lookup("hysteresis ctr10", 32'h0000_1000, 1'b1, 32'h0000_2000);
    upd(32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000);
    cyc(); idle();
    lookup("hysteresis ctr01", 32'h0000_1000, 1'b0, 32'h0000_1004);

    lookup("alias miss", 32'h0000_3000, 1'b0, 32'h0000_3004);
    lookup("wrap miss", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    do_reset();
    fetch(32'h0000_1000);
    upd(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_1004);
    cyc(); upd_valid = 1'b0;
    chk("same-cycle miss taken", 32'(predict_taken), 32'd0);
    chk("same-cycle miss pc", predicted_pc, 32'h0000_1004);
    cyc(); idle();
    chk("next-cycle hit taken", 32'(predict_taken), 32'd1);
    chk("next-cycle hit pc", predicted_pc, 32'h0000_2000);

    fetch(32'h0000_1000); cyc();
    stall = 1'b1; pc_if = 32'h0000_3000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall valid hold", 32'(pred_valid), 32'd1);
      chk("stall taken hold", 32'(predict_taken), 32'd1);
      chk("stall pc hold", predicted_pc, 32'h0000_2000);
    end
    idle(); cyc();
    chk("after stall drop", 32'(pred_valid), 32'd0);

    fetch(32'h0000_1000); cyc();
    chk("pre-flush valid", 32'(pred_valid), 32'd1);
    flush = 1'b1; stall = 1'b1; cyc(); idle();
    chk("flush clears", 32'(pred_valid), 32'd0);

    upd(32'h0000_1040, 32'h0000_5000, 1'b1, 1'b0, 32'h0000_1044);
    cyc(); idle();
    rst = 1'b1;
    #1;
    chk("reset kills pulse", 32'(mispredict), 32'd0);
    cyc(); rst = 1'b0;
    cyc();
    chk("no pulse after reset", 32'(mispredict), 32'd0);
    chk("no lookup after reset", 32'(pred_valid), 32'd0);

    for (int i = 0; i < 300; i++) begin
      fetch_valid = 1'($urandom_range(1));
      pc_if       = pick_pc($urandom);
      stall       = ($urandom_range(3) == 0);
      flush       = ($urandom_range(7) == 0);
      upd_valid   = 1'($urandom_range(1));
      upd_pc      = pick_pc($urandom);
      upd_target  = 32'h0000_2000 + 32'($urandom_range(3)) * 32'h100;
      upd_taken   = 1'($urandom_range(1));
      upd_pred_taken = 1'($urandom_range(1));
      upd_pred_pc = ($urandom_range(1) == 1) ? upd_target : upd_pc + 32'd4;
      cyc();
    end
    idle(); cyc(); cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_reader.md
BRANCH_TARGET_READER -- requirements
Module: branch_target_reader

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- Width, 32: PC and target width.
- Entries, 128: table depth, indexed by PC[8:2].
- TagW, 5: tag width, taken from PC[13:9].

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1: sole clock; all state updates on its rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- pc_if_i, in, Width: fetch-stage PC to look up.
- fetch_valid_i, in, 1: pc_if_i is valid this cycle.
- stall_i, in, 1: fetch stalled; lookup outputs hold.
- flush_i, in, 1: kill the in-flight lookup.
- predict_taken_o, out, 1: prediction is taken.
- predicted_pc_o, out, Width: next fetch PC.
- pred_valid_o, out, 1: predict_taken_o and predicted_pc_o are valid.
- upd_valid_i, in, 1: resolved branch from ID this cycle.
- upd_pc_i, in, Width: PC of the resolved branch.
- upd_target_i, in, Width: computed target (PC + imm).
- upd_taken_i, in, 1: resolved outcome.
- upd_pred_taken_i, in, 1: prediction that travelled with the branch.
- upd_pred_pc_i, in, Width: predicted next PC that travelled with the branch.
- mispredict_o, out, 1: one-cycle redirect pulse.
- correct_pc_o, out, Width: redirect PC, valid when mispredict_o = 1.

Function
REQ-003 Each entry SHALL hold: valid (1b), tag (TagW), target (Width), and ctr, a 2-bit saturating counter.

REQ-004 Index SHALL be PC[8:2] and tag SHALL be PC[13:9], for both the lookup and the update paths.

REQ-005 Lookup SHALL be accepted at a clock edge when fetch_valid_i=1 and stall_i=0 and flush_i=0.
- Results appear the following cycle (latency 1), from registered index/tag/PC.

REQ-006 Hit SHALL be defined as: entry valid and stored tag equals the registered tag.

REQ-007 Lookup results SHALL be:
- predict_taken_o = hit AND ctr[1].
- predicted_pc_o = target when predict_taken_o=1, else registered PC + 4, truncated to Width (wrap-around modulo 2^Width).

REQ-008 pred_valid_o SHALL be 1 for exactly one cycle per accepted lookup.
- With stall_i=1, pred_valid_o, predict_taken_o and predicted_pc_o hold their values.

REQ-009 flush_i=1 SHALL clear pred_valid_o at the next edge, regardless of stall_i.

REQ-010 Update on hit (upd_valid_i=1):
- ctr increments, saturating at 2'b11, if upd_taken_i=1.
- ctr decrements, saturating at 2'b00, if upd_taken_i=0.
- target is overwritten with upd_target_i only when upd_taken_i=1.

REQ-011 Update on miss (upd_valid_i=1):
- If upd_taken_i=1: allocate the entry (valid=1, tag, target=upd_target_i, ctr=2'b10), replacing any occupant.
- If upd_taken_i=0: leave the table unchanged.

REQ-012 When a lookup and an update address the same index in the same cycle, the lookup SHALL return pre-update contents (read-before-write, no bypass).

REQ-013 mispredict_o SHALL be registered, asserting one cycle after an update when either:
- upd_pred_taken_i differs from upd_taken_i, or
- upd_taken_i=1 and upd_pred_pc_i differs from upd_target_i.

REQ-014 correct_pc_o SHALL be upd_target_i if upd_taken_i=1, else upd_pc_i + 4 (wrapped). It is registered alongside mispredict_o.

REQ-015 mispredict_o SHALL be a single-cycle pulse and SHALL be 0 in any cycle not preceded by an update edge.

REQ-016 Back-to-back updates SHALL be accepted every cycle, each producing its own independent mispredict_o evaluation.

Reset
REQ-017 While rst_i=1, independent of clk_i:
- All valid bits SHALL be 0 and all ctr SHALL be 2'b01.
- pred_valid_o, predict_taken_o, mispredict_o SHALL be 0.
- predicted_pc_o and correct_pc_o SHALL be 0.

REQ-018 Reset asserted mid-operation SHALL discard any in-flight lookup result or pending mispredict pulse.
- No output pulse appears after rst_i deasserts until a new request is accepted.

REQ-019 Target and tag storage need not be reset; valid bits gate their use.

Verification
REQ-020 Cold lookup: reset, then fetch pc_if_i=0x0000_1000 -> next cycle pred_valid_o=1, predict_taken_o=0, predicted_pc_o=0x0000_1004.

REQ-021 Allocate then hit:
- Update upd_pc_i=0x0000_1000, upd_target_i=0x0000_2000, taken=1, pred_taken=0 -> mispredict_o=1 and correct_pc_o=0x0000_2000 one cycle later.
- Subsequent lookup of 0x1000 -> predict_taken_o=1, predicted_pc_o=0x0000_2000.

REQ-022 Counter saturation and hysteresis:
- Three further taken updates leave ctr=2'b11.
- One not-taken update makes ctr=2'b10, so the lookup still predicts taken.
- A second not-taken update makes ctr=2'b01, so the lookup predicts PC+4.

REQ-023 Aliasing and wrap:
- Lookup 0x0000_3000 (same index as 0x1000, different tag) after allocating 0x1000 -> miss, predicted_pc_o=0x0000_3004.
- Lookup 0xFFFF_FFFC on a miss -> predicted_pc_o=0x0000_0000.

REQ-024 Same-cycle lookup and allocate of 0x0000_1000 -> that lookup misses; a lookup one cycle later hits.

REQ-025 Control corner cases:
- stall_i held 3 cycles -> outputs stable throughout.
- flush_i -> pred_valid_o=0 next cycle.
- rst_i asserted in the cycle after a mispredicting update -> no mispredict_o pulse.
